// File: rtl/piso_pkg.sv
// ============================================================================
//  piso_pkg : shared types and helpers for the PISO serializer
//  Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/piso_serializer_if.sv
// ============================================================================
//  piso_serializer_if : parallel-word handshake plus framed serial output
//  Rev 1.0  : initial release
// ============================================================================
`default_nettype none

interface piso_serializer_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );

endinterface

`default_nettype wire

// File: rtl/piso_hold_buf.sv
// ============================================================================
//  piso_hold_buf : one-entry word buffer with full flag, load and take controls
//  Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module piso_hold_buf #(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic             take,
  input  wire logic [WIDTH-1:0] din,
  output logic      [WIDTH-1:0] dout,
  output logic                  full
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;

  // load only happens while empty and take only while full, so they never collide
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (load) begin
      r_data <= din;
      r_full <= 1'b1;
    end else if (take) begin
      r_full <= 1'b0;
    end
  end

  assign dout = r_data;
  assign full = r_full;

endmodule

`default_nettype wire

// File: rtl/piso_serializer.sv
// ============================================================================
//  piso_serializer : valid/ready word in, framed bit-serial stream out
//  Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input wire logic          clk,
  input wire logic          rst,
  piso_serializer_if.slave  bus
);

  localparam int              CW         = cnt_width(WIDTH);
  localparam logic [0:0]      S_IDLE     = IDLE;
  localparam logic [0:0]      S_SHIFT    = SHIFT;
  localparam logic [CW-1:0]   C_LAST_CNT = CW'(WIDTH - 1);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;

  logic             w_hold_full;
  logic [WIDTH-1:0] w_hold_data;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_free;
  logic             w_take;
  logic             w_load_hold;
  logic             w_ser_valid;
  logic             w_bit;

  assign w_in_ready  = !w_hold_full && !rst;
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_free      = (r_state == S_IDLE) || (r_cnt == C_LAST_CNT);
  assign w_take      = w_free && w_hold_full;
  // a word arriving while the shifter frees with an empty hold bypasses the buffer
  assign w_load_hold = w_accept && !w_free;

  piso_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .load (w_load_hold),
    .take (w_take),
    .din  (bus.in_data),
    .dout (w_hold_data),
    .full (w_hold_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_free) begin
      r_cnt <= '0;
      if (w_hold_full) begin
        r_shift <= w_hold_data;
        r_state <= S_SHIFT;
      end else if (w_accept) begin
        r_shift <= bus.in_data;
        r_state <= S_SHIFT;
      end else begin
        r_shift <= '0;
        r_state <= S_IDLE;
      end
    end else begin
      r_cnt   <= r_cnt + 1'b1;
      r_shift <= MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
    end
  end

  assign w_ser_valid   = (r_state == S_SHIFT);
  assign w_bit         = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

  assign bus.in_ready  = w_in_ready;
  assign bus.ser_valid = w_ser_valid;
  assign bus.ser_out   = w_ser_valid && w_bit;
  assign bus.ser_first = w_ser_valid && (r_cnt == '0);
  assign bus.ser_last  = w_ser_valid && (r_cnt == C_LAST_CNT);
  assign bus.busy      = w_ser_valid || w_hold_full;

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// ============================================================================
//  tb_piso_serializer : scoreboard bench for three serializer configurations
//  Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module tb_piso_serializer;

  logic clk;
  logic rst;

  piso_serializer_if #(.WIDTH(4)) if_a ();
  piso_serializer_if #(.WIDTH(4)) if_b ();
  piso_serializer_if #(.WIDTH(8)) if_c ();

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // expected {ser_out, ser_first, ser_last} per bit, one queue per instance
  logic [2:0] q_a[$];
  logic [2:0] q_b[$];
  logic [2:0] q_c[$];
  int run_len[3];
  int last_run[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int q_size(input int inst);
    case (inst)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  function automatic logic [2:0] q_pop(input int inst);
    case (inst)
      0:       return q_a.pop_front();
      1:       return q_b.pop_front();
      default: return q_c.pop_front();
    endcase
  endfunction

  function automatic void push_word(input int inst, input logic [7:0] d);
    int w;
    logic b;
    logic [2:0] e;
    w = (inst == 2) ? 8 : 4;
    for (int i = 0; i < w; i++) begin
      b = (inst == 1) ? d[i] : d[w-1-i];
      e = {b, (i == 0), (i == w - 1)};
      case (inst)
        0:       q_a.push_back(e);
        1:       q_b.push_back(e);
        default: q_c.push_back(e);
      endcase
    end
  endfunction

  function automatic logic ready_of(input int inst);
    case (inst)
      0:       return if_a.in_ready;
      1:       return if_b.in_ready;
      default: return if_c.in_ready;
    endcase
  endfunction

  task automatic set_in(input int inst, input logic v, input logic [7:0] d);
    case (inst)
      0:       begin if_a.in_valid = v; if_a.in_data = d[3:0]; end
      1:       begin if_b.in_valid = v; if_b.in_data = d[3:0]; end
      default: begin if_c.in_valid = v; if_c.in_data = d;      end
    endcase
  endtask

  // leaves in_valid high on return so successive calls stream back-to-back
  task automatic send(input int inst, input logic [7:0] d, output int waits);
    waits = 0;
    set_in(inst, 1'b1, d);
    while (!ready_of(inst) && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!ready_of(inst)) begin
      chk("accept_timeout", {31'b0, ready_of(inst)}, 32'd1);
      set_in(inst, 1'b0, d);
    end else begin
      push_word(inst, d);
      @(posedge clk); #1;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic mon(input int inst, input logic v, input logic o, input logic f, input logic l);
    if (v) begin
      run_len[inst]++;
      if (q_size(inst) == 0) chk($sformatf("unexpected_bit_%0d", inst), {31'b0, v}, 32'd0);
      else                   chk($sformatf("bit_%0d", inst), {29'b0, o, f, l}, {29'b0, q_pop(inst)});
    end else begin
      if (run_len[inst] > 0) last_run[inst] = run_len[inst];
      run_len[inst] = 0;
      chk($sformatf("idle_quiet_%0d", inst), {29'b0, o, f, l}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, if_a.ser_valid, if_a.ser_out, if_a.ser_first, if_a.ser_last);
    mon(1, if_b.ser_valid, if_b.ser_out, if_b.ser_first, if_b.ser_last);
    mon(2, if_c.ser_valid, if_c.ser_out, if_c.ser_first, if_c.ser_last);
  end

  initial begin
    int w;
    for (int i = 0; i < 3; i++) begin
      run_len[i]  = 0;
      last_run[i] = 0;
    end
    rst = 1'b1;
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    set_in(2, 1'b0, 8'h00);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, if_a.in_ready}, 32'd0);
    chk("rst_busy", {31'b0, if_a.busy}, 32'd0);
    chk("rst_valid", {31'b0, if_c.ser_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_a", {31'b0, if_a.in_ready}, 32'd1);
    chk("post_rst_ready_c", {31'b0, if_c.in_ready}, 32'd1);

    // single word, first bit the cycle after acceptance
    send(0, 8'h0B, w);
    set_in(0, 1'b0, 8'h00);
    @(negedge clk);
    chk("latency_valid", {31'b0, if_a.ser_valid}, 32'd1);
    chk("latency_first", {31'b0, if_a.ser_first}, 32'd1);
    cycles(6);
    chk("single_busy", {31'b0, if_a.busy}, 32'd0);
    chk("single_run", last_run[0], 32'd4);

    // back-to-back through the hold buffer
    send(0, 8'h0A, w);
    send(0, 8'h05, w);
    chk("hold_ready_low", {31'b0, if_a.in_ready}, 32'd0);
    chk("hold_busy", {31'b0, if_a.busy}, 32'd1);
    send(0, 8'h0C, w);
    chk("hold_wait_cycles", w, 32'd3);
    set_in(0, 1'b0, 8'h00);
    cycles(16);
    chk("b2b_run", last_run[0], 32'd12);
    chk("b2b_busy", {31'b0, if_a.busy}, 32'd0);

    // idle gap
    send(0, 8'h09, w);
    set_in(0, 1'b0, 8'h00);
    cycles(6);
    chk("gap_valid", {31'b0, if_a.ser_valid}, 32'd0);
    chk("gap_busy", {31'b0, if_a.busy}, 32'd0);
    chk("gap_run", last_run[0], 32'd4);

    // bypass: accept on the last bit of a word with the hold empty
    send(0, 8'h09, w);
    set_in(0, 1'b0, 8'h00);
    w = 0;
    @(negedge clk);
    while (!if_a.ser_last && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("wait_last", {31'b0, if_a.ser_last}, 32'd1);
    send(0, 8'h06, w);
    set_in(0, 1'b0, 8'h00);
    @(negedge clk);
    chk("bypass_first", {31'b0, if_a.ser_first}, 32'd1);
    chk("bypass_hold_empty", {31'b0, if_a.in_ready}, 32'd1);
    cycles(8);
    chk("bypass_run", last_run[0], 32'd8);

    // reset during bit 2 of 4'hF with 4'h3 held
    send(0, 8'h0F, w);
    send(0, 8'h03, w);
    set_in(0, 1'b0, 8'h00);
    cycles(1);
    rst = 1'b1;
    @(posedge clk); #1;
    q_a.delete();
    @(negedge clk);
    chk("midrst_valid", {31'b0, if_a.ser_valid}, 32'd0);
    chk("midrst_busy", {31'b0, if_a.busy}, 32'd0);
    chk("midrst_ready", {31'b0, if_a.in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", {31'b0, if_a.in_ready}, 32'd1);
    cycles(10);
    chk("midrst_busy_after", {31'b0, if_a.busy}, 32'd0);

    // LSB-first instance
    send(1, 8'h0B, w);
    set_in(1, 1'b0, 8'h00);
    cycles(6);
    chk("lsb_run", last_run[1], 32'd4);

    // 8-bit instance
    send(2, 8'hA5, w);
    set_in(2, 1'b0, 8'h00);
    cycles(10);
    chk("w8_run", last_run[2], 32'd8);

    chk("q_a_drained", q_a.size(), 32'd0);
    chk("q_b_drained", q_b.size(), 32'd0);
    chk("q_c_drained", q_c.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
